// File: rtl/ft245_device.sv
// FT245-style FIFO bus device: an FPGA-side master strobes ft_rd_n/ft_wr_n to move bytes
// between the host AXI-Stream ports and the bus through an RX and a TX byte FIFO.
module ft245_device #(
   parameter int RX_DEPTH       = 16,
   parameter int TX_DEPTH       = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ft_d_in,
   output logic [7:0] ft_d_out,
   output logic       ft_d_oe,
   input  logic       ft_rd_n,
   input  logic       ft_wr_n,
   output logic       ft_rxf_n,
   output logic       ft_txe_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       err_rd_empty,
   output logic       err_wr_full,
   output logic       err_conflict
);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
   localparam logic [RCW-1:0] REC_LAST = RCW'(RECOVER_CYCLES - 1);

   typedef enum logic [1:0] {R_IDLE, R_DRIVE, R_RECOVER} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_RECOVER} wr_state_t;

   rd_state_t rd_state;
   wr_state_t wr_state;
   logic [RCW-1:0] rd_cnt, wr_cnt;

   logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
   logic rd_s, wr_s, rd_prev, wr_prev;
   logic rd_fall, rd_rise, wr_fall, wr_rise;
   logic ready_q;

   logic [7:0]   rx_mem [RX_DEPTH];
   logic [RAW:0] rx_wptr, rx_rptr;
   logic         rx_full, rx_empty, rx_empty_q, rx_push, rx_pop;

   logic [7:0]   tx_mem [TX_DEPTH];
   logic [TAW:0] tx_wptr, tx_wptr_d, tx_rptr;
   logic         tx_full, tx_push, tx_pop;

   // strobe synchronizers, idle high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_sync <= '1;
         wr_sync <= '1;
         rd_prev <= 1'b1;
         wr_prev <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         rd_sync <= (rd_sync << 1) | SYNC_STAGES'(ft_rd_n);
         wr_sync <= (wr_sync << 1) | SYNC_STAGES'(ft_wr_n);
         rd_prev <= rd_s;
         wr_prev <= wr_s;
         ready_q <= 1'b1;
      end
   end

   assign rd_s    = rd_sync[SYNC_STAGES-1];
   assign wr_s    = wr_sync[SYNC_STAGES-1];
   assign rd_fall = rd_prev & ~rd_s;
   assign rd_rise = ~rd_prev & rd_s;
   assign wr_fall = wr_prev & ~wr_s;
   assign wr_rise = ~wr_prev & wr_s;

   assign rx_empty      = (rx_wptr == rx_rptr);
   assign rx_full       = (rx_wptr[RAW] != rx_rptr[RAW]) && (rx_wptr[RAW-1:0] == rx_rptr[RAW-1:0]);
   assign s_axis_tready = ready_q & ~rx_full;
   assign rx_push       = s_axis_tvalid & s_axis_tready;
   assign rx_pop        = (rd_state == R_DRIVE) && rd_rise && !rx_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wptr    <= '0;
         rx_rptr    <= '0;
         rx_empty_q <= 1'b1;
      end else begin
         if (rx_push) rx_wptr <= rx_wptr + 1'b1;
         if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
         rx_empty_q <= rx_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wptr[RAW-1:0]] <= s_axis_tdata;
   end

   // the read side sees a delayed write pointer, so a pushed byte becomes visible one cycle later
   assign tx_full       = (tx_wptr[TAW] != tx_rptr[TAW]) && (tx_wptr[TAW-1:0] == tx_rptr[TAW-1:0]);
   assign m_axis_tvalid = (tx_rptr != tx_wptr_d);
   assign m_axis_tdata  = tx_mem[tx_rptr[TAW-1:0]];
   assign tx_pop        = m_axis_tvalid & m_axis_tready;
   assign tx_push       = (wr_state == W_IDLE) && wr_fall && !ft_txe_n && !tx_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wptr   <= '0;
         tx_wptr_d <= '0;
         tx_rptr   <= '0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + 1'b1;
         if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
         tx_wptr_d <= tx_wptr;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr[TAW-1:0]] <= ft_d_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state     <= R_IDLE;
         rd_cnt       <= '0;
         ft_d_out     <= '0;
         ft_d_oe      <= 1'b0;
         ft_rxf_n     <= 1'b1;
         err_rd_empty <= 1'b0;
      end else begin
         if (rd_fall && ft_rxf_n) err_rd_empty <= 1'b1;
         case (rd_state)
            R_IDLE: begin
               ft_rxf_n <= rx_empty_q;
               if (rd_fall && !ft_rxf_n) begin
                  rd_state <= R_DRIVE;
                  ft_d_out <= rx_mem[rx_rptr[RAW-1:0]];
                  ft_d_oe  <= 1'b1;
                  ft_rxf_n <= 1'b0;
               end
            end
            R_DRIVE: begin
               if (rd_rise) begin
                  rd_state <= R_RECOVER;
                  rd_cnt   <= '0;
                  ft_d_oe  <= 1'b0;
                  ft_rxf_n <= 1'b1;
               end
            end
            R_RECOVER: begin
               if (rd_cnt == REC_LAST) begin
                  rd_state <= R_IDLE;
                  ft_rxf_n <= rx_empty;
               end else begin
                  rd_cnt <= rd_cnt + 1'b1;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state     <= W_IDLE;
         wr_cnt       <= '0;
         ft_txe_n     <= 1'b1;
         err_wr_full  <= 1'b0;
         err_conflict <= 1'b0;
      end else begin
         if (wr_fall && ft_txe_n) err_wr_full <= 1'b1;
         if (!rd_s && !wr_s)      err_conflict <= 1'b1;
         case (wr_state)
            W_IDLE: begin
               ft_txe_n <= tx_full;
               if (tx_push) begin
                  wr_state <= W_ACTIVE;
                  ft_txe_n <= 1'b1;
               end
            end
            W_ACTIVE: begin
               if (wr_rise) begin
                  wr_state <= W_RECOVER;
                  wr_cnt   <= '0;
               end
            end
            W_RECOVER: begin
               if (wr_cnt == REC_LAST) begin
                  wr_state <= W_IDLE;
                  ft_txe_n <= tx_full;
               end else begin
                  wr_cnt <= wr_cnt + 1'b1;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ft245_device.sv
// Directed bench for ft245_device: transaction table plus hand-written corner sequences.
module tb_ft245_device;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ft_d_in = '0;
   logic [7:0] ft_d_out;
   logic       ft_d_oe;
   logic       ft_rd_n = 1'b1;
   logic       ft_wr_n = 1'b1;
   logic       ft_rxf_n, ft_txe_n;
   logic [7:0] s_axis_tdata = '0;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready = 1'b0;
   logic       err_rd_empty, err_wr_full, err_conflict;

   int n_checks = 0;
   int n_errors = 0;

   logic       tr_oe  [0:31];
   logic       tr_rxf [0:31];
   logic [7:0] tr_dout[0:31];
   logic       tr_txe [0:31];
   logic       tr_tv  [0:31];
   logic [7:0] tr_td  [0:31];

   typedef enum logic [1:0] {OP_SEND, OP_RD, OP_WR, OP_POP} op_t;
   typedef struct {
      op_t        op;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [14];

   ft245_device #(.RX_DEPTH(16), .TX_DEPTH(16), .SYNC_STAGES(2), .RECOVER_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .ft_d_in(ft_d_in), .ft_d_out(ft_d_out), .ft_d_oe(ft_d_oe),
      .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .err_rd_empty(err_rd_empty), .err_wr_full(err_wr_full), .err_conflict(err_conflict)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait timed out", name);
   endtask

   task automatic wait_rxf_low(input string name);
      int unsigned k = 0;
      while (ft_rxf_n !== 1'b0 && k < 200) begin @(negedge clk); k++; end
      if (ft_rxf_n !== 1'b0) timeout_fail(name);
   endtask

   task automatic wait_txe_low(input string name);
      int unsigned k = 0;
      while (ft_txe_n !== 1'b0 && k < 200) begin @(negedge clk); k++; end
      if (ft_txe_n !== 1'b0) timeout_fail(name);
   endtask

   task automatic axis_send(input logic [7:0] b);
      int unsigned k = 0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      while (s_axis_tready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      if (s_axis_tready !== 1'b1) timeout_fail("axis send ready");
      @(negedge clk);
      s_axis_tvalid = 1'b0;
   endtask

   // trace index k is the k-th falling clock edge after the strobe goes low
   task automatic rd_trace(input int unsigned len);
      ft_rd_n = 1'b0;
      for (int unsigned k = 1; k <= len + 6; k++) begin
         @(negedge clk);
         tr_oe[k] = ft_d_oe; tr_rxf[k] = ft_rxf_n; tr_dout[k] = ft_d_out;
         if (k == len) ft_rd_n = 1'b1;
      end
   endtask

   task automatic wr_trace(input int unsigned len, input logic [7:0] data);
      ft_d_in = data;
      ft_wr_n = 1'b0;
      for (int unsigned k = 1; k <= len + 6; k++) begin
         @(negedge clk);
         tr_txe[k] = ft_txe_n; tr_tv[k] = m_axis_tvalid; tr_td[k] = m_axis_tdata;
         if (k == len) ft_wr_n = 1'b1;
      end
   endtask

   task automatic pop_check(input string name, input logic [7:0] exp);
      int unsigned k = 0;
      while (m_axis_tvalid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      if (m_axis_tvalid !== 1'b1) timeout_fail(name);
      else check8(name, m_axis_tdata, exp);
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
   endtask

   initial begin
      logic any_oe, all_rxf;
      int unsigned k;

      vecs[0]  = '{OP_SEND, 8'h11, 8'h00};
      vecs[1]  = '{OP_SEND, 8'h22, 8'h00};
      vecs[2]  = '{OP_SEND, 8'h33, 8'h00};
      vecs[3]  = '{OP_RD,   8'h00, 8'h11};
      vecs[4]  = '{OP_WR,   8'h44, 8'h00};
      vecs[5]  = '{OP_WR,   8'h55, 8'h00};
      vecs[6]  = '{OP_POP,  8'h00, 8'h44};
      vecs[7]  = '{OP_RD,   8'h00, 8'h22};
      vecs[8]  = '{OP_SEND, 8'h66, 8'h00};
      vecs[9]  = '{OP_RD,   8'h00, 8'h33};
      vecs[10] = '{OP_RD,   8'h00, 8'h66};
      vecs[11] = '{OP_POP,  8'h00, 8'h55};
      vecs[12] = '{OP_WR,   8'h77, 8'h00};
      vecs[13] = '{OP_POP,  8'h00, 8'h77};

      // reset values
      repeat (3) @(negedge clk);
      check1("rst rxf_n", ft_rxf_n, 1'b1);
      check1("rst txe_n", ft_txe_n, 1'b1);
      check1("rst d_oe", ft_d_oe, 1'b0);
      check8("rst d_out", ft_d_out, 8'h00);
      check1("rst m_tvalid", m_axis_tvalid, 1'b0);
      check1("rst s_tready", s_axis_tready, 1'b0);
      check1("rst err_rd_empty", err_rd_empty, 1'b0);
      check1("rst err_wr_full", err_wr_full, 1'b0);
      check1("rst err_conflict", err_conflict, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check1("post-rst txe_n", ft_txe_n, 1'b0);
      check1("post-rst s_tready", s_axis_tready, 1'b1);

      // first byte latency, then a 5-cycle read of 0xA5
      s_axis_tdata = 8'hA5; s_axis_tvalid = 1'b1;
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      check1("rx lat t+0 rxf_n", ft_rxf_n, 1'b1);
      @(negedge clk);
      check1("rx lat t+1 rxf_n", ft_rxf_n, 1'b1);
      @(negedge clk);
      check1("rx lat t+2 rxf_n", ft_rxf_n, 1'b0);
      rd_trace(5);
      check1("rd a5 oe before sync", tr_oe[2], 1'b0);
      check1("rd a5 oe on", tr_oe[3], 1'b1);
      check8("rd a5 data", tr_dout[3], 8'hA5);
      check1("rd a5 oe late pulse", tr_oe[7], 1'b1);
      check1("rd a5 oe off", tr_oe[8], 1'b0);
      check1("rd a5 rxf recov1", tr_rxf[8], 1'b1);
      check1("rd a5 rxf recov2", tr_rxf[9], 1'b1);
      check1("rd a5 rxf empty", tr_rxf[10], 1'b1);
      check1("rd a5 rxf empty late", tr_rxf[11], 1'b1);
      check1("rd a5 err_rd_empty", err_rd_empty, 1'b0);

      // 5-cycle write of 0x3C with the sink stalled
      wait_txe_low("wr 3c txe");
      wr_trace(5, 8'h3C);
      check1("wr 3c txe before", tr_txe[2], 1'b0);
      check1("wr 3c txe forced", tr_txe[3], 1'b1);
      check1("wr 3c tvalid t+0", tr_tv[3], 1'b0);
      check1("wr 3c tvalid t+1", tr_tv[4], 1'b1);
      check8("wr 3c tdata", tr_td[4], 8'h3C);
      check1("wr 3c txe recov", tr_txe[9], 1'b1);
      check1("wr 3c txe low", tr_txe[10], 1'b0);
      check1("wr 3c tvalid held", tr_tv[11], 1'b1);
      pop_check("wr 3c pop", 8'h3C);
      check1("wr 3c tvalid after pop", m_axis_tvalid, 1'b0);

      // read strobe with nothing to read
      rd_trace(5);
      any_oe = 1'b0; all_rxf = 1'b1;
      for (int unsigned i = 1; i <= 11; i++) begin
         any_oe  = any_oe | tr_oe[i];
         all_rxf = all_rxf & tr_rxf[i];
      end
      check1("empty rd oe never", any_oe, 1'b0);
      check1("empty rd rxf stays high", all_rxf, 1'b1);
      check1("empty rd err_rd_empty", err_rd_empty, 1'b1);

      // transaction table
      for (int unsigned i = 0; i < 14; i++) begin
         case (vecs[i].op)
            OP_SEND: axis_send(vecs[i].din);
            OP_RD: begin
               wait_rxf_low($sformatf("tbl%0d rxf", i));
               rd_trace(4);
               check1($sformatf("tbl%0d rd oe", i), tr_oe[3], 1'b1);
               check8($sformatf("tbl%0d rd data", i), tr_dout[3], vecs[i].exp);
            end
            OP_WR: begin
               wait_txe_low($sformatf("tbl%0d txe", i));
               wr_trace(4, vecs[i].din);
            end
            OP_POP: pop_check($sformatf("tbl%0d pop", i), vecs[i].exp);
            default: ;
         endcase
      end

      // fill TX to 16, overflow attempt, drain in order
      check1("fill err_wr_full before", err_wr_full, 1'b0);
      for (int unsigned i = 0; i < 16; i++) begin
         wait_txe_low("fill txe");
         wr_trace(4, 8'hC0 + 8'(i));
      end
      repeat (3) @(negedge clk);
      check1("fill txe_n high when full", ft_txe_n, 1'b1);
      check1("fill err_wr_full still 0", err_wr_full, 1'b0);
      wr_trace(4, 8'hEE);
      check1("fill 17th err_wr_full", err_wr_full, 1'b1);
      for (int unsigned i = 0; i < 16; i++) pop_check($sformatf("fill pop %0d", i), 8'hC0 + 8'(i));
      check1("fill tvalid drained", m_axis_tvalid, 1'b0);

      // simultaneous read and write strobes
      check1("conflict err before", err_conflict, 1'b0);
      axis_send(8'h9A);
      wait_rxf_low("conflict rxf");
      wait_txe_low("conflict txe");
      ft_d_in = 8'h4B; ft_rd_n = 1'b0; ft_wr_n = 1'b0;
      for (int unsigned i = 1; i <= 11; i++) begin
         @(negedge clk);
         tr_oe[i] = ft_d_oe; tr_dout[i] = ft_d_out;
         if (i == 5) begin ft_rd_n = 1'b1; ft_wr_n = 1'b1; end
      end
      check1("conflict err_conflict", err_conflict, 1'b1);
      check1("conflict rd oe", tr_oe[3], 1'b1);
      check8("conflict rd data", tr_dout[3], 8'h9A);
      pop_check("conflict tx pop", 8'h4B);
      check1("conflict rx empty", ft_rxf_n, 1'b1);

      // 40-byte stream with back-to-back reads
      fork
         begin
            for (int unsigned i = 0; i < 40; i++) axis_send(8'(i * 37 + 5));
         end
         begin
            for (int unsigned j = 0; j < 40; j++) begin
               wait_rxf_low("stream rxf");
               rd_trace(3);
               check8($sformatf("stream byte %0d", j), tr_dout[3], 8'(j * 37 + 5));
            end
         end
      join

      // reset in the middle of a read drive
      axis_send(8'hD1);
      wait_rxf_low("rst-drive rxf");
      ft_rd_n = 1'b0;
      k = 0;
      while (ft_d_oe !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      if (ft_d_oe !== 1'b1) timeout_fail("rst-drive oe");
      #2 rst_n = 1'b0;
      #1;
      check1("rst-drive oe released", ft_d_oe, 1'b0);
      check1("rst-drive rxf_n", ft_rxf_n, 1'b1);
      @(negedge clk);
      ft_rd_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check1("rst-drive rxf_n after", ft_rxf_n, 1'b1);
      check1("rst-drive err_rd_empty cleared", err_rd_empty, 1'b0);
      check1("rst-drive err_wr_full cleared", err_wr_full, 1'b0);
      check1("rst-drive err_conflict cleared", err_conflict, 1'b0);
      axis_send(8'hE2);
      wait_rxf_low("rst-drive new byte rxf");
      rd_trace(4);
      check8("rst-drive fifo was emptied", tr_dout[3], 8'hE2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/ft245_device.md
FT245_DEVICE -- requirements
Module: ft245_device

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 16: host-to-FPGA byte FIFO depth; power of two and at least 2.
REQ-002 SHALL have parameter TX_DEPTH, default 16: FPGA-to-host byte FIFO depth; power of two and at least 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flop stages on ft_rd_n and ft_wr_n.
REQ-004 SHALL have parameter RECOVER_CYCLES, default 2: cycles ft_rxf_n/ft_txe_n held high after a strobe ends.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ft_d_in  in  8  bus data driven by the FPGA-side master.
- ft_d_out  out  8  bus data driven by this device.
- ft_d_oe  out  1  high while this device drives the bus.
- ft_rd_n  in  1  asynchronous read strobe, active-low.
- ft_wr_n  in  1  asynchronous write strobe, active-low.
- ft_rxf_n  out  1  low means a byte is readable.
- ft_txe_n  out  1  low means a byte is writable.
- s_axis_tdata/tvalid/tready  in/in/out  8/1/1  host bytes toward the FPGA.
- m_axis_tdata/tvalid/tready  out/out/in  8/1/1  bytes received from the FPGA.
- err_rd_empty, err_wr_full, err_conflict  out  1 each  sticky protocol-error flags.

Function
REQ-006 SHALL synchronize ft_rd_n and ft_wr_n through SYNC_STAGES flops, each reset to 1, and SHALL detect edges only on the synchronized signals.
REQ-007 SHALL accept a byte into the RX FIFO when s_axis_tvalid and s_axis_tready are both high; s_axis_tready = RX FIFO not full.
REQ-008 SHALL present the TX FIFO head on m_axis_tdata; m_axis_tvalid = TX FIFO not empty; pop happens on tvalid and tready.
REQ-009 SHALL run a read FSM with states R_IDLE, R_DRIVE, R_RECOVER.
REQ-010 R_IDLE -> R_DRIVE on a synchronized rd fall while ft_rxf_n is low; the next cycle, ft_d_out = RX head and ft_d_oe = 1.
REQ-011 R_DRIVE -> R_RECOVER on a synchronized rd rise: pop RX head, ft_d_oe = 0, ft_rxf_n forced high.
REQ-012 R_RECOVER SHALL last RECOVER_CYCLES cycles, then -> R_IDLE; ft_rxf_n = RX FIFO empty, registered.
REQ-013 A synchronized rd fall while ft_rxf_n is high SHALL be ignored and SHALL set err_rd_empty; no pop, ft_d_oe stays 0.
REQ-014 SHALL run a write FSM with states W_IDLE, W_ACTIVE, W_RECOVER.
REQ-015 W_IDLE -> W_ACTIVE on a synchronized wr fall while ft_txe_n is low: push ft_d_in, sampled that cycle, into the TX FIFO; ft_txe_n forced high.
REQ-016 W_ACTIVE -> W_RECOVER on a synchronized wr rise; after RECOVER_CYCLES -> W_IDLE; ft_txe_n = TX FIFO full, registered.
REQ-017 A synchronized wr fall while ft_txe_n is high SHALL be ignored and SHALL set err_wr_full.
REQ-018 Strobes SHALL be tracked only while low, with no strobe-length limit; the master holds ft_d_in for the whole wr pulse, and the wr pulse is at least SYNC_STAGES+2 cycles.
REQ-019 rd and wr both synchronized-low in the same cycle SHALL set err_conflict; both FSMs proceed independently, and ft_d_oe follows the read FSM only.
REQ-020 RX push and RX pop in the same cycle SHALL both occur, and the count is unchanged; the same holds for TX.
REQ-021 FIFO pointers SHALL be log2(DEPTH)+1 bits, wrap modulo 2*DEPTH, full = MSBs differ and the rest equal, empty = equal.
REQ-022 Latency: first byte into an empty RX FIFO at edge t -> ft_rxf_n low after edge t+2; TX push at edge t -> m_axis_tvalid high after edge t+1.
REQ-023 Error flags SHALL clear only on reset.

Reset
REQ-024 rst_n low SHALL immediately set ft_rxf_n=1, ft_txe_n=1, ft_d_oe=0, ft_d_out=0, m_axis_tvalid=0, s_axis_tready=0 and all error flags to 0.
REQ-025 Reset SHALL empty both FIFOs and put both FSMs in their IDLE state.
REQ-026 Reset during R_DRIVE SHALL release the bus at once, with no pop completion.
REQ-027 After rst_n rises, ft_txe_n SHALL go low and s_axis_tready high within 2 cycles.

Verification
REQ-028 Send 0xA5 on s_axis, then rd pulse of 5 cycles: ft_d_out=0xA5 with ft_d_oe=1 during the pulse; ft_rxf_n high for 2 cycles after it, then stays high (empty).
REQ-029 Write 0x3C via wr pulse of 5 cycles with m_axis_tready=0: m_axis_tvalid=1, tdata=0x3C; ft_txe_n high until the 2-cycle recovery ends, then low.
REQ-030 Fill TX with 16 writes and no m_axis_tready: ft_txe_n stays high; a 17th wr pulse sets err_wr_full, and the FIFO holds the first 16 bytes in order.
REQ-031 rd pulse with empty RX FIFO: err_rd_empty=1, ft_d_oe never asserts, no state change.
REQ-032 Stream 40 bytes while issuing rd pulses back-to-back at the rxf_n rate: all 40 bytes are read in order, with wrap-around exercised.
REQ-033 Assert rst_n low mid-R_DRIVE: ft_d_oe=0 in the same cycle; after release, ft_rxf_n=1 and the RX FIFO is empty.
